// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO stream reader: strobe FSM encoding and counter width.
package fifo_stream_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level flags; reset value is a parameter
// so empty/full style flags can come out of reset in their safe state.
module sync_2ff #(
  parameter logic reset_val = 1'b0
) (
  input  logic clk_i,
  input  logic n_reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      meta_q <= reset_val;
      sync_q <= reset_val;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Strobe-driven FIFO consumer delivering bytes on a valid/ready stream.
// Optional 2-entry output buffer: define FIFO_STREAM_READER_PREFETCH_EN.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int data_width    = 8,
  parameter int strobe_width  = 2,
  parameter int settle_cycles = 1
) (
  input  logic                  clk_i,
  input  logic                  n_reset_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [data_width-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic [data_width-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [COUNT_W-1:0]    count_o,
  output logic                  busy_o,
  output state_t                state_o
);

  localparam int cnt_max = (strobe_width > settle_cycles + 2) ? strobe_width : settle_cycles + 2;
  localparam int cnt_w   = $clog2(cnt_max + 1);

  // Stream handshake: a byte moves when m_valid_o && m_ready_i on a rising clk_i;
  // m_data_o holds while m_valid_o && !m_ready_i; valid never drops without a pop.

  state_t             state_q, state_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic               rd_q;
  logic               empty_s;
  logic               capture;
  logic               pop;
  logic               space;
  logic               start;
  logic [COUNT_W-1:0] count_q;

  sync_2ff #(.reset_val(1'b1)) u_empty_sync (
    .clk_i     (clk_i),
    .n_reset_i (n_reset_i),
    .d_i       (fifo_empty_i),
    .q_o       (empty_s)
  );

  assign pop   = m_valid_o && m_ready_i;
  assign start = enable_i && !empty_s && space;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HIGH;
          cnt_d   = cnt_w'(strobe_width);
        end
      end
      HIGH: begin
        cnt_d = cnt_q - cnt_w'(1);
        if (cnt_q == cnt_w'(1)) begin
          capture = 1'b1;
          state_d = LOW;
          cnt_d   = cnt_w'(settle_cycles + 2);
        end
      end
      LOW: begin
        cnt_d = cnt_q - cnt_w'(1);
        if (cnt_q == cnt_w'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The strobe comes from its own flop so the FIFO never sees a decode glitch.
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= (state_d == HIGH);
      if (pop) count_q <= count_q + COUNT_W'(1);
    end
  end

`ifdef FIFO_STREAM_READER_PREFETCH_EN
  logic [data_width-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q;
  logic                  in_flight;

  assign in_flight = (state_q == HIGH);
  assign space     = (occ_q + 2'(in_flight)) < 2'd2;

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (capture) begin
        mem_q[wr_ptr_q] <= fifo_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + 2'(capture) - 2'(pop);
    end
  end

  assign m_data_o  = mem_q[rd_ptr_q];
  assign m_valid_o = (occ_q != 2'd0);
`else
  logic [data_width-1:0] data_q;
  logic                  valid_q;

  // A read is only started into an empty (or emptying) register, so capture never overwrites.
  assign space = !valid_q || pop;

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (capture) data_q <= fifo_data_i;
      valid_q <= capture || (valid_q && !pop);
    end
  end

  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;
`endif

  assign fifo_rd_o = rd_q;
  assign count_o   = count_q;
  assign busy_o    = (state_q != IDLE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: strobe-FIFO model, stream scoreboard, vector table
// plus directed sequences for back-pressure, enable gating, reset and count wrap.
module tb_fifo_stream_reader;
  import fifo_stream_pkg::*;

  localparam int DW     = 8;
  localparam int STROBE = 2;
  localparam int SETTLE = 1;
  localparam int PERIOD = STROBE + SETTLE + 3;
`ifdef FIFO_STREAM_READER_PREFETCH_EN
  localparam int EXP_BP_PULSES = 2;
`else
  localparam int EXP_BP_PULSES = 1;
`endif

  logic          clk = 1'b0;
  logic          n_reset_i = 1'b0;
  logic          enable_i = 1'b1;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_data_i = '0;
  logic          fifo_rd_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [15:0]   count_o;
  logic          busy_o;
  state_t        state_o;

  fifo_stream_reader #(
    .data_width    (DW),
    .strobe_width  (STROBE),
    .settle_cycles (SETTLE)
  ) dut (
    .clk_i        (clk),
    .n_reset_i    (n_reset_i),
    .enable_i     (enable_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_o    (fifo_rd_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .count_o      (count_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- strobe FIFO model ----------------
  logic [DW-1:0] fifo_mem [256];
  int            fifo_wr_cnt = 0;
  int            fifo_rd_cnt = 0;
  int            rd_pulses   = 0;

  assign fifo_empty_i = (fifo_wr_cnt == fifo_rd_cnt);

  always @(posedge fifo_rd_o) begin
    rd_pulses++;
    fifo_data_i = fifo_mem[fifo_rd_cnt[7:0]];
  end

  always @(negedge fifo_rd_o) begin
    if (fifo_rd_cnt < fifo_wr_cnt) fifo_rd_cnt++;
  end

  // ---------------- drivers ----------------
  int ready_pct = 100;
  always @(posedge clk) begin
    #1;
    m_ready_i = ($urandom_range(0, 99) < ready_pct);
  end

  logic [DW-1:0] exp_q[$];

  task automatic fifo_write(input logic [DW-1:0] b);
    fifo_mem[fifo_wr_cnt[7:0]] = b;
    fifo_wr_cnt++;
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o && fifo_empty_i) done = 1'b1;
    end
    check({name, "_drain"}, done, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rd_high(input int max_cycles, input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (fifo_rd_o) done = 1'b1;
    end
    check({name, "_rd_seen"}, done, 1'b1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [15:0]   exp_count = '0;
  int            preload_seq = 0;
  int            preload_seen = 0;
  int            hs_times[$];
  int            hi_cnt = 0;
  int            rise_cyc = 0;
  logic          rd_prev = 1'b0;
  logic          valid_prev = 1'b0;
  logic          stall = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (!n_reset_i) begin
      exp_q.delete();
      exp_count  = '0;
      hi_cnt     = 0;
      rd_prev    = 1'b0;
      valid_prev = 1'b0;
      stall      = 1'b0;
    end else begin
      if (preload_seen != preload_seq) begin
        exp_count    = 16'hFFFE;
        preload_seen = preload_seq;
      end
      check("count", {16'b0, count_o}, {16'b0, exp_count});
      if (fifo_rd_o) hi_cnt++;
      else if (hi_cnt != 0) begin
        check("rd_width", hi_cnt, STROBE);
        hi_cnt = 0;
      end
      if (fifo_rd_o && !rd_prev) begin
        rise_cyc = cyc;
        check("rd_nonempty", fifo_empty_i, 1'b0);
      end
      if (m_valid_o && !valid_prev) check("latency", cyc - rise_cyc, STROBE);
      if (stall) check("stable", m_data_o, stall_data);
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) check("unexpected_byte", 1'b1, 1'b0);
        else check("data", m_data_o, exp_q.pop_front());
        exp_count = exp_count + 16'd1;
        hs_times.push_back(cyc);
      end
      stall      = m_valid_o && !m_ready_i;
      stall_data = m_data_o;
      rd_prev    = fifo_rd_o;
      valid_prev = m_valid_o;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int n_bytes;
    int ready_pct;
    int exp_pulses;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int h0;
    vecs[0] = '{n_bytes: 1, ready_pct: 100, exp_pulses: 1};
    vecs[1] = '{n_bytes: 4, ready_pct: 70,  exp_pulses: 4};
    vecs[2] = '{n_bytes: 6, ready_pct: 40,  exp_pulses: 6};
    vecs[3] = '{n_bytes: 3, ready_pct: 15,  exp_pulses: 3};
    vecs[4] = '{n_bytes: 2, ready_pct: 100, exp_pulses: 2};

    // reset values
    n_reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", fifo_rd_o, 1'b0);
    check("rst_valid", m_valid_o, 1'b0);
    check("rst_data", m_data_o, 8'h00);
    check("rst_count", count_o, 16'h0000);
    check("rst_busy", busy_o, 1'b0);
    check("rst_state", state_o, IDLE);
    @(posedge clk);
    #1 n_reset_i = 1'b1;

    // single byte
    ready_pct = 100;
    p0 = rd_pulses;
    fifo_write(8'hA5);
    wait_drain(100, "single");
    check("single_pulses", rd_pulses - p0, 1);
    check("single_count", count_o, 16'd1);
    check("single_empty", fifo_empty_i, 1'b1);

    // vector table
    foreach (vecs[v]) begin
      ready_pct = vecs[v].ready_pct;
      p0 = rd_pulses;
      for (int i = 0; i < vecs[v].n_bytes; i++) fifo_write(DW'($urandom_range(0, 255)));
      wait_drain(vecs[v].n_bytes * 100 + 50, "vec");
      check("vec_pulses", rd_pulses - p0, vecs[v].exp_pulses);
    end

    // burst: back-to-back reads at the minimum period
    ready_pct = 100;
    @(posedge clk);
    p0 = rd_pulses;
    h0 = hs_times.size();
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
    wait_drain(300, "burst");
    check("burst_pulses", rd_pulses - p0, 8);
    check("burst_hs", hs_times.size() - h0, 8);
    for (int i = 1; i < 8 && h0 + i < hs_times.size(); i++)
      check("burst_spacing", hs_times[h0 + i] - hs_times[h0 + i - 1], PERIOD);

    // back-pressure
    ready_pct = 0;
    repeat (2) @(posedge clk);
    #2;
    p0 = rd_pulses;
    fifo_write(8'h3C);
    fifo_write(8'hC3);
    fifo_write(8'h5A);
    repeat (40) @(negedge clk);
    check("bp_pulses", rd_pulses - p0, EXP_BP_PULSES);
    check("bp_valid", m_valid_o, 1'b1);
    check("bp_data", m_data_o, 8'h3C);
    ready_pct = 100;
    wait_drain(200, "bp");
    check("bp_pulses_all", rd_pulses - p0, 3);

    // enable gating during HIGH
    p0 = rd_pulses;
    fifo_write(8'h11);
    fifo_write(8'h22);
    fifo_write(8'h33);
    wait_rd_high(50, "en");
    @(posedge clk);
    #1 enable_i = 1'b0;
    repeat (30) @(negedge clk);
    check("en_pulses", rd_pulses - p0, 1);
    check("en_pending", exp_q.size(), 2);
    check("en_busy", busy_o, 1'b0);
    enable_i = 1'b1;
    wait_drain(200, "en");
    check("en_pulses_all", rd_pulses - p0, 3);

    // reset in the middle of a strobe
    fifo_write(8'h77);
    fifo_write(8'h88);
    wait_rd_high(50, "rst_mid");
    @(posedge clk);
    #1 n_reset_i = 1'b0;
    #1;
    check("rstmid_rd", fifo_rd_o, 1'b0);
    check("rstmid_valid", m_valid_o, 1'b0);
    check("rstmid_count", count_o, 16'h0000);
    check("rstmid_busy", busy_o, 1'b0);
    fifo_wr_cnt = fifo_rd_cnt;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 n_reset_i = 1'b1;
    p0 = rd_pulses;
    repeat (20) @(negedge clk);
    check("rstmid_no_read", rd_pulses - p0, 0);
    check("rstmid_count_after", count_o, 16'h0000);
    check("rstmid_valid_after", m_valid_o, 1'b0);

    // count wrap from a preloaded value
    @(posedge clk);
    #1 force dut.count_q = 16'hFFFE;
    preload_seq++;
    #1 release dut.count_q;
    repeat (2) @(negedge clk);
    check("wrap_preload", count_o, 16'hFFFE);
    fifo_write(8'hE1);
    fifo_write(8'hE2);
    fifo_write(8'hE3);
    wait_drain(200, "wrap");
    check("wrap_count", count_o, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Clocked consumer for the strobe-driven `fifo` block. It generates correctly shaped `rd` pulses into the FIFO, captures the byte the FIFO presents, and delivers it downstream on a clk_i-domain valid/ready stream. It sits between any strobe-style FIFO (CPU→peripheral mailboxes, UART/keyboard buffers) and clocked logic that needs back-pressure.

## Interface
Parameters:
- data_width, 8, stream and FIFO data width
- strobe_width, 2, clk_i cycles fifo_rd_o is held high (minimum 1)
- settle_cycles, 1, extra clk_i cycles fifo_rd_o is held low before fifo_empty_i is re-evaluated (minimum 0)

Ports:
- clk_i  in  1  system clock; all logic is on posedge
- n_reset_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  permits new FIFO reads
- fifo_empty_i  in  1  FIFO empty flag, asynchronous to clk_i
- fifo_data_i  in  data_width  FIFO output register
- fifo_rd_o  out  1  read strobe to FIFO; rising edge loads data, falling edge advances tail
- m_data_o  out  data_width  stream data
- m_valid_o  out  1  stream valid
- m_ready_i  in  1  stream ready
- count_o  out  16  bytes delivered (handshakes), wraps modulo 2^16
- busy_o  out  1  high in any state other than IDLE

## Operation
- fifo_empty_i passes through a 2-flop synchronizer, which resets to 1 (empty). The synchronized copy is called `empty_s`.
- State machine:
  - **IDLE**
    - Start condition: enable_i && !empty_s && space available.
    - When the start condition holds: go to HIGH, raise fifo_rd_o, load the strobe counter with strobe_width.
  - **HIGH**
    - fifo_rd_o=1. Decrement the counter each cycle.
    - In the last HIGH cycle, capture fifo_data_i into the output buffer.
    - Then go to LOW and load the counter with settle_cycles+2.
  - **LOW**
    - fifo_rd_o=0. Decrement the counter.
    - At zero, return to IDLE. The +2 covers synchronizer latency, so a stale empty_s is never acted on.
- A transaction always completes once started. enable_i falling only blocks the next start. Downstream stall does not abort an in-flight strobe, because space is reserved at start.
- Space available:
  - Single buffer: !m_valid_o, or m_valid_o && m_ready_i in the same cycle.
  - Prefetch (see Configuration): number of occupied entries plus in-flight reads is less than 2.
- Stream rules:
  - m_data_o is stable while m_valid_o && !m_ready_i.
  - A handshake (m_valid_o && m_ready_i) pops one entry and increments count_o.
  - A capture and a pop in the same cycle are both honoured.
- Order is preserved. No byte is dropped or duplicated.

## Timing
- Reset values:
  - fifo_rd_o=0, m_valid_o=0, m_data_o=0, count_o=0, busy_o=0, state IDLE, empty_s=1.
  - Reset asserted mid-HIGH forces fifo_rd_o low immediately. The FIFO is reset by the same n_reset_i, so the resulting falling edge is harmless.
- After reset deassertion with the FIFO non-empty, the first fifo_rd_o rise comes 2 cycles later (synchronizer), then one IDLE cycle.
- Latency from fifo_rd_o rise to m_valid_o high is strobe_width cycles (data captured at the end of the last HIGH cycle).
- Minimum read period is strobe_width + settle_cycles + 3 cycles. With defaults that is 6 cycles per byte.
- FIFO goes empty mid-burst: empty_s is checked only in IDLE, after the LOW wait, so the read count equals the number of bytes written.

## Configuration
- `FIFO_STREAM_READER_PREFETCH_EN`
  - **Defined:** a 2-entry output buffer (head/tail pointers plus a 2-bit occupancy count). The next FIFO read may start while m_valid_o is stalled, hiding the strobe latency.
  - **Undefined:** a single output register. A read starts only when the register is empty or being popped that cycle.
- Stream protocol and ordering are identical in both builds.

## Structure
- Shared package `fifo_stream_pkg` holds:
  - state encoding constants: IDLE=2'd0, HIGH=2'd1, LOW=2'd2
  - COUNT_W=16
- Natural sub-module `sync_2ff` (parameterized reset value). It is reused for other asynchronous FIFO flags in the codebase.

## Test plan
- **Single byte:** reset; write 8'hA5 to the FIFO; m_ready_i=1.
  - fifo_rd_o is high for exactly 2 cycles.
  - m_valid_o pulses once with 8'hA5; count_o=1; fifo_empty_i returns to 1.
- **Burst:** write 8'h01..8'h08 (FIFO full); m_ready_i=1.
  - Eight handshakes in order 01..08, spaced 6 cycles apart.
  - count_o=8; no fifo_rd_o pulse while empty_s=1.
- **Back-pressure:** 3 bytes queued; m_ready_i=0 for 40 cycles.
  - Without the prefetch macro: 1 fifo_rd_o pulse.
  - With the prefetch macro: 2 pulses.
  - m_data_o holds the first byte; after release all 3 arrive in order.
- **Enable gating:** drop enable_i during HIGH.
  - The current byte completes and is delivered.
  - No further fifo_rd_o pulses until enable_i=1.
- **Reset mid-strobe:** assert n_reset_i during HIGH.
  - fifo_rd_o=0, m_valid_o=0, count_o=0 immediately.
  - After release, the FIFO (reset too) is empty and no read occurs.
- **Counter wrap:** preload via 65536 handshakes (force or long run).
  - count_o wraps 16'hFFFF → 16'h0000.
